// File: rtl/fir_pkg.sv
// Shared defaults and the rounding/saturation helper for the FIR output stage.
// Also used by bench models.
package fir_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefShift = 7;
  localparam int unsigned DefOutW  = 12;

  // Round-half-up divide by 2^shift, then clamp to out_w bits. Needs shift >= 1.
  function automatic logic [31:0] scale_sat(input logic [31:0]  in,
                                            input int unsigned shift,
                                            input int unsigned out_w);
    logic [32:0] sum;
    logic [32:0] sat_max;
    sum     = {1'b0, in} + (33'd1 << (shift - 1));
    sum     = sum >> shift;
    sat_max = (33'd1 << out_w) - 33'd1;
    return (sum > sat_max) ? sat_max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/fir_decim_buffer_if.sv
// Sample-in / buffered-sample-out handshake bundle of the FIR decimating output stage.
interface fir_decim_buffer_if #(
  parameter int unsigned DATA_W = fir_pkg::DefDataW,
  parameter int unsigned OUT_W  = fir_pkg::DefOutW
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-wrap-bit pointers; write/read enables arrive pre-qualified.
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);
  localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LvlFull);
  assign empty   = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/fir_decim_buffer.sv
// FIR output stage: descale with round-half-up, saturate, keep every DECIM-th sample,
// and buffer kept samples in a FIFO so the consumer can stall the output independently.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned SHIFT  = DefShift,
  parameter int unsigned OUT_W  = DefOutW,
  parameter int unsigned DECIM  = 4,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_decim_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PhaseLast = PW'(DECIM - 1);
  localparam logic [PW-1:0] PhaseOne  = PW'(1);

  logic [PW-1:0]    phase_q, phase_d;
  logic             keep;
  logic [OUT_W-1:0] scaled;
  logic [OUT_W-1:0] stg_data_q;
  logic             wr_pend_q;
  logic             fifo_full, fifo_empty;
  logic [OUT_W-1:0] fifo_rd_data;
  logic             rd_fire, wr_fire, drop;
  logic             overflow_d;

  assign keep   = bus.in_valid && (phase_q == '0);
  assign scaled = OUT_W'(scale_sat(32'(bus.in_data), SHIFT, OUT_W));

  always_comb begin
    phase_d = phase_q;
    if (bus.in_valid) phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhaseOne;
  end

  // A full FIFO still accepts the pending sample if the head leaves on the same edge.
  assign rd_fire = bus.out_ready && !fifo_empty;
  assign wr_fire = wr_pend_q && (!fifo_full || rd_fire);
  assign drop    = wr_pend_q && fifo_full && !rd_fire;

  always_comb begin
    overflow_d = overflow;
    if (clear_ovf) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= '0;
      stg_data_q <= '0;
      wr_pend_q  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      wr_pend_q <= keep;
      overflow  <= overflow_d;
      if (keep) stg_data_q <= scaled;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_fire),
    .wr_data (stg_data_q),
    .rd_en   (rd_fire),
    .rd_data (fifo_rd_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  // Unreset storage never reaches the port while empty.
  assign bus.out_data  = fifo_empty ? '0 : fifo_rd_data;

endmodule

// File: doc/fir_decim_buffer.md
# fir_decim_buffer

Output stage placed directly downstream of the 4-tap moving-average FIR filter. It takes the filter's scaled 16-bit result, removes the ×128 coefficient scaling with round-half-up, saturates to the output width, and keeps every DECIM-th sample. Kept samples are buffered in a small FIFO with a valid/ready interface, so the consumer can stall without disturbing the free-running filter.

## Interface

Parameters:
- DATA_W, 16: input sample width, unsigned.
- SHIFT, 7: right shift that removes the coefficient scale (log2 128).
- OUT_W, 12: output sample width, unsigned.
- DECIM, 4: decimation factor, ≥1; DECIM=1 keeps every sample.
- DEPTH, 8: FIFO depth, power of two, ≥2.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: in_data holds a new filter result this cycle.
- in_data, in, DATA_W: filter output sample.
- out_valid, out, 1: FIFO not empty.
- out_ready, in, 1: consumer accepts out_data this cycle.
- out_data, out, OUT_W: head-of-FIFO sample.
- level, out, $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- overflow, out, 1: sticky flag, a kept sample was dropped.
- clear_ovf, in, 1: synchronous clear of overflow.

## Operation

- Reset values (reset low, asynchronous): out_valid=0, out_data=0, level=0, overflow=0. The phase counter, pointers, and stage-1 register all clear. FIFO memory contents are not reset.
- Phase counter: range 0..DECIM-1. It advances only on in_valid and wraps from DECIM-1 to 0.
  - A sample is kept when in_valid=1 and phase=0.
  - The first in_valid after reset is therefore kept.
- Scaling: r = (in_data + 2^(SHIFT-1)) >> SHIFT, computed in DATA_W+1 bits so the add cannot wrap. If r > 2^OUT_W−1, the result is 2^OUT_W−1; otherwise it is r[OUT_W-1:0].
- Stage 1 register: on the edge where a sample is kept, it captures the scaled value and sets wr_pend=1. On any other edge wr_pend=0.
- FIFO write: on the edge after capture, when wr_pend=1.
  - If the FIFO is not full, or it is full and a read occurs on the same edge, the value is written.
  - Otherwise the value is dropped and overflow is set.
- FIFO read: on any edge with out_valid & out_ready. out_ready while empty has no effect.
- Simultaneous read and write: level is unchanged, both pointers advance, and behaviour is correct at level 0 < n ≤ DEPTH.
- Write into an empty FIFO: out_valid rises the cycle after the write edge. There is no fall-through bypass.
- out_data is driven from mem[rd_ptr] combinationally and is stable while out_valid=1 and out_ready=0.
- Pointers have one extra wrap bit for full/empty detection. Wrap-around at DEPTH is seamless.
- overflow: set by a drop and cleared by clear_ovf. If both happen on the same edge, set wins.

## Timing

- Latency: a kept sample presented at edge N is in stage 1 after N, written at N+1, and visible with out_valid=1 from N+1 until it is read. That is 2 edges from input to output.
- Throughput: one kept sample per cycle when DECIM=1 and out_ready=1. The FIFO never fills in that case.
- level updates on the same edge as the write or read that changes it.
- Reset asserted mid-stream: everything returns to reset values immediately, and the pending stage-1 sample is lost. After release, the next in_valid is phase 0.

## Structure

- Shared package `fir_pkg`:
  - Parameter defaults: DATA_W, SHIFT, OUT_W.
  - Function `scale_sat(in)` for the rounding and saturation.
  - This package is reused by bench models.
- One natural sub-module `sync_fifo` (parameters WIDTH, DEPTH): holds the memory, the pointers, level, and the full/empty logic.
- The top module holds the phase counter, the scaling stage, and the overflow flag.

## Test plan

- Reset, then in_valid=1 every cycle with in_data=0,128,256,…,128·k, DECIM=4, out_ready=1:
  - out_data sequence is 0,4,8,…
  - first out_valid appears 2 edges after the first input.
- Rounding: in_data=63→0, 64→1, 191→1, 192→2.
- Saturation (OUT_W=8): in_data=16'hFFFF gives r=512, so out_data=255.
- out_ready=0 with DECIM=1:
  - level climbs to DEPTH.
  - The next kept sample is dropped and overflow=1.
  - clear_ovf clears overflow.
  - The FIFO drains in the original order.
- FIFO full with out_ready=1 and wr_pend on the same edge: no drop, level stays 8, and data order is preserved across a pointer wrap.
- reset pulsed low mid-stream with 3 entries queued: level, out_valid, and overflow drop to 0 asynchronously, and the next in_valid after release is kept.
